// File: rtl/crc32_stream.sv
// -----------------------------------------------------------------------------
// crc32_stream
//
// Streaming CRC-32 engine producing zlib/PNG chunk checksums
// (poly 0x04C11DB7, reflected in/out, preset INIT_VAL, final XOR XOR_OUT).
// Bytes arrive packed MSB-first in DATA_WD-bit beats. BYTES_PER_CYC bytes
// are folded per clock. A beat wider than one fold step is parked in a hold
// register and drained in the FOLD state.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start_i    preset the CRC register and (re)enter RUN; aborts any message
//   val_i      beat valid
//   rdy_o      beat can be accepted this cycle (decoded from state only)
//   dat_i      beat, first byte in dat_i[DATA_WD-1 -: 8]
//   lst_i      beat is the last of the message (sampled on accept)
//   bcnt_i     valid bytes in a last beat, counted from the MSB byte
//   done_o     one-cycle pulse when the CRC is complete
//   val_o      level, dat_o holds the final CRC
//   dat_o      reflect(crc_r) ^ XOR_OUT
//
// Handshake: a beat transfers on a rising clock edge where val_i=1,
// rdy_o=1 and start_i=0. rdy_o never looks at val_i, and start_i wins
// over a simultaneous beat, which is then dropped.
// -----------------------------------------------------------------------------
module crc32_stream #(
    parameter int          DATA_WD       = 32,
    parameter int          BYTES_PER_CYC = 1,
    parameter logic [31:0] INIT_VAL      = 32'hFFFF_FFFF,
    parameter logic [31:0] XOR_OUT       = 32'hFFFF_FFFF,
    parameter int          BCNT_WD       = $clog2(DATA_WD / 8) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               val_i,
    output logic               rdy_o,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               lst_i,
    input  logic [BCNT_WD-1:0] bcnt_i,
    output logic               done_o,
    output logic               val_o,
    output logic [31:0]        dat_o
);

    localparam int NB    = DATA_WD / 8;
    localparam int BPC   = BYTES_PER_CYC;
    localparam int BPC_W = BPC * 8;

    localparam logic [31:0]        POLY  = 32'h04C1_1DB7;
    localparam logic [BCNT_WD-1:0] NB_C  = BCNT_WD'(NB);
    localparam logic [BCNT_WD-1:0] BPC_C = BCNT_WD'(BPC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    logic [31:0]          crc_r;
    logic [DATA_WD-1:0]   hold_r;   // unfolded bytes of the current beat, MSB aligned
    logic [BCNT_WD-1:0]   rem_r;    // bytes still waiting in hold_r
    logic                 last_r;   // current beat closes the message

    logic [BCNT_WD-1:0]   beat_bytes;
    logic [BCNT_WD-1:0]   first_n;
    logic [BCNT_WD-1:0]   rest_n;
    logic [BCNT_WD-1:0]   fold_n;
    logic [BCNT_WD-1:0]   rem_after;
    logic [BCNT_WD-1:0]   n_sel;
    logic [BPC_W-1:0]     src;
    logic [31:0]          stage [0:BPC];
    logic [31:0]          crc_fold;

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] reflect32(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = w[31-i];
        end
        return r;
    endfunction

    // One byte through the non-reflected (MSB-first) register. Reflecting
    // the input byte here and the register on output gives the reflected CRC.
    function automatic logic [31:0] fold_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {reflect8(b), 24'h0};
        for (int i = 0; i < 8; i++) begin
            r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    always_comb begin
        // Byte count of the incoming beat; oversize counts clamp to a full beat.
        if (lst_i) begin
            beat_bytes = (bcnt_i > NB_C) ? NB_C : bcnt_i;
        end else begin
            beat_bytes = NB_C;
        end
        first_n   = (beat_bytes > BPC_C) ? BPC_C : beat_bytes;
        rest_n    = beat_bytes - first_n;
        fold_n    = (rem_r > BPC_C) ? BPC_C : rem_r;
        rem_after = rem_r - fold_n;

        if (state == FOLD) begin
            src   = hold_r[DATA_WD-1 -: BPC_W];
            n_sel = fold_n;
        end else begin
            src   = dat_i[DATA_WD-1 -: BPC_W];
            n_sel = first_n;
        end

        // Cascade of BPC byte stages; the tap mux picks the output after
        // n_sel stages so a short final step folds only its valid bytes.
        stage[0] = crc_r;
        for (int i = 0; i < BPC; i++) begin
            stage[i+1] = fold_byte(stage[i], src[BPC_W-1-8*i -: 8]);
        end
        crc_fold = crc_r;
        for (int k = 1; k <= BPC; k++) begin
            if (n_sel == BCNT_WD'(k)) begin
                crc_fold = stage[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            crc_r  <= INIT_VAL;
            hold_r <= '0;
            rem_r  <= '0;
            last_r <= 1'b0;
            done_o <= 1'b0;
            val_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start_i) begin
                state  <= RUN;
                crc_r  <= INIT_VAL;
                rem_r  <= '0;
                last_r <= 1'b0;
                val_o  <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (val_i) begin
                            crc_r  <= crc_fold;
                            hold_r <= dat_i << BPC_W;
                            rem_r  <= rest_n;
                            last_r <= lst_i;
                            if (rest_n != '0) begin
                                state <= FOLD;
                            end else if (lst_i) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                                val_o  <= 1'b1;
                            end
                        end
                    end
                    FOLD: begin
                        crc_r  <= crc_fold;
                        hold_r <= hold_r << BPC_W;
                        rem_r  <= rem_after;
                        if (rem_after == '0) begin
                            if (last_r) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                                val_o  <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE wait for start_i; beats are ignored.
                    end
                endcase
            end
        end
    end

    assign rdy_o = (state == RUN);
    assign dat_o = reflect32(crc_r) ^ XOR_OUT;

endmodule

// File: tb/tb_crc32_stream.sv
// -----------------------------------------------------------------------------
// tb_crc32_stream
//
// Two instances share clock and reset: index 0 folds one byte per clock,
// index 1 folds a whole 32-bit beat per clock. A behavioural model tracks,
// per instance, the accepted byte stream (bytewise reflected CRC) and the
// cycle count each beat must occupy, and a compare process checks every
// output on every falling edge.
// -----------------------------------------------------------------------------
module tb_crc32_stream;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_BUSY = 2;
    localparam int M_DONE = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       start_v = '0;
    logic [1:0]       val_v   = '0;
    logic [1:0]       lst_v   = '0;
    logic [1:0][31:0] din_v   = '0;
    logic [1:0][2:0]  bcnt_v  = '0;
    logic [1:0]       rdy_v;
    logic [1:0]       done_v;
    logic [1:0]       valo_v;
    logic [1:0][31:0] dout_v;

    crc32_stream #(.DATA_WD(32), .BYTES_PER_CYC(1)) u_bpc1 (
        .clk(clk), .rst(rst), .start_i(start_v[0]), .val_i(val_v[0]), .rdy_o(rdy_v[0]),
        .dat_i(din_v[0]), .lst_i(lst_v[0]), .bcnt_i(bcnt_v[0]),
        .done_o(done_v[0]), .val_o(valo_v[0]), .dat_o(dout_v[0])
    );

    crc32_stream #(.DATA_WD(32), .BYTES_PER_CYC(4)) u_bpc4 (
        .clk(clk), .rst(rst), .start_i(start_v[1]), .val_i(val_v[1]), .rdy_o(rdy_v[1]),
        .dat_i(din_v[1]), .lst_i(lst_v[1]), .bcnt_i(bcnt_v[1]),
        .done_o(done_v[1]), .val_o(valo_v[1]), .dat_o(dout_v[1])
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%08h expected=%08h", name, u, $time, act, exp);
        end
    endtask

    // Bytewise reflected CRC register update (LSB-first, reflected poly).
    function automatic logic [31:0] ref_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_crc(input logic [127:0] v, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = ref_upd(c, v[127-8*i -: 8]);
        end
        return c ^ 32'hFFFF_FFFF;
    endfunction

    // behavioural model
    int          m_mode [2] = '{M_IDLE, M_IDLE};
    int          m_busy [2] = '{0, 0};
    bit          m_fin  [2] = '{1'b0, 1'b0};
    logic [31:0] m_crc  [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bit          e_done [2] = '{1'b0, 1'b0};
    bit          e_val  [2] = '{1'b0, 1'b0};
    logic [31:0] e_crc  [2] = '{32'h0, 32'h0};

    function automatic int bpc_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    task automatic model_complete(input int u);
        if (m_fin[u]) begin
            m_mode[u] = M_DONE;
            e_done[u] = 1'b1;
            e_val[u]  = 1'b1;
            e_crc[u]  = m_crc[u] ^ 32'hFFFF_FFFF;
        end else begin
            m_mode[u] = M_RUN;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                m_mode[u] = M_IDLE;
                m_busy[u] = 0;
                m_fin[u]  = 1'b0;
                m_crc[u]  = 32'hFFFF_FFFF;
                e_done[u] = 1'b0;
                e_val[u]  = 1'b0;
                e_crc[u]  = 32'h0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                int nbytes;
                int steps;
                int cyc;
                e_done[u] = 1'b0;
                if (start_v[u]) begin
                    m_mode[u] = M_RUN;
                    m_crc[u]  = 32'hFFFF_FFFF;
                    e_val[u]  = 1'b0;
                end else if (m_mode[u] == M_RUN && val_v[u]) begin
                    if (lst_v[u]) nbytes = (int'(bcnt_v[u]) > 4) ? 4 : int'(bcnt_v[u]);
                    else          nbytes = 4;
                    for (int i = 0; i < nbytes; i++) begin
                        m_crc[u] = ref_upd(m_crc[u], din_v[u][31-8*i -: 8]);
                    end
                    steps    = (nbytes + bpc_of(u) - 1) / bpc_of(u);
                    cyc      = (lst_v[u] && steps < 1) ? 1 : steps;
                    m_fin[u] = lst_v[u];
                    if (cyc <= 1) begin
                        model_complete(u);
                    end else begin
                        m_mode[u] = M_BUSY;
                        m_busy[u] = cyc - 1;
                    end
                end else if (m_mode[u] == M_BUSY) begin
                    m_busy[u]--;
                    if (m_busy[u] == 0) model_complete(u);
                end
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            check("rdy",  u, 32'(rdy_v[u]),  32'(m_mode[u] == M_RUN));
            check("done", u, 32'(done_v[u]), 32'(e_done[u]));
            check("valo", u, 32'(valo_v[u]), 32'(e_val[u]));
            if (e_val[u]) check("crc", u, dout_v[u], e_crc[u]);
            if (m_mode[u] == M_IDLE) check("dat_idle", u, dout_v[u], 32'h0);
        end
    end

    // driver tasks (all inputs change 1 time unit after a rising edge)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int u);
        start_v[u] = 1'b1;
        step();
        start_v[u] = 1'b0;
    endtask

    task automatic send_beat(input int u, input logic [31:0] d, input logic l,
                             input logic [2:0] bc, input bit gaps);
        bit acc;
        bit v;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            v          = !(gaps && $urandom_range(0, 2) == 0);
            val_v[u]   = v;
            din_v[u]   = v ? d : $urandom;
            lst_v[u]   = l;
            bcnt_v[u]  = bc;
            acc        = v && rdy_v[u];
            step();
            guard++;
        end
        if (!acc) check("accept_timeout", u, 32'd0, 32'd1);
        val_v[u] = 1'b0;
        lst_v[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, input bit use_exp);
        int guard;
        guard = 0;
        while (!valo_v[u] && guard < 100) begin
            step();
            guard++;
        end
        check("done_timeout", u, 32'(valo_v[u]), 32'd1);
        if (use_exp && exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("crc_literal", u, dout_v[u], e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int u;
        int nb;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy0", 0, 32'(rdy_v[0]), 32'd0);
        check("rst_dat1", 1, dout_v[1], 32'h0);
        rst = 1'b0;
        step();

        // pin the reference model against known checksums
        check("ref_iend",  0, ref_crc({32'h49454E44, 96'h0}, 4), 32'hAE42_6082);
        check("ref_digits", 0, ref_crc({72'h313233343536373839, 56'h0}, 9), 32'hCBF4_3926);
        check("ref_empty", 0, ref_crc(128'h0, 0), 32'h0);

        // "IEND" on the full-width engine
        do_start(1);
        exp_q.push_back(32'hAE42_6082);
        send_beat(1, 32'h49454E44, 1'b1, 3'd4, 1'b0);
        check("iend_done_pulse", 1, 32'(done_v[1]), 32'd1);
        wait_done(1, 1'b1);
        step();
        check("iend_held", 1, dout_v[1], 32'hAE42_6082);

        // "123456789" on the byte-serial engine, then with random val gaps
        for (int pass = 0; pass < 2; pass++) begin
            do_start(0);
            exp_q.push_back(32'hCBF4_3926);
            send_beat(0, 32'h31323334, 1'b0, 3'd0, pass == 1);
            send_beat(0, 32'h35363738, 1'b0, 3'd0, pass == 1);
            send_beat(0, 32'h39000000, 1'b1, 3'd1, pass == 1);
            wait_done(0, 1'b1);
        end

        // empty message on both engines
        for (int k = 0; k < 2; k++) begin
            do_start(k);
            exp_q.push_back(32'h0);
            send_beat(k, $urandom, 1'b1, 3'd0, 1'b0);
            wait_done(k, 1'b1);
        end

        // oversize byte count clamps to a full beat
        do_start(1);
        exp_q.push_back(32'hAE42_6082);
        send_beat(1, 32'h49454E44, 1'b1, 3'd7, 1'b0);
        wait_done(1, 1'b1);

        // abort mid-FOLD, then start together with a beat drops that beat
        do_start(0);
        send_beat(0, $urandom, 1'b0, 3'd0, 1'b0);
        send_beat(0, $urandom, 1'b0, 3'd0, 1'b0);
        do_start(0);
        start_v[0] = 1'b1;
        val_v[0]   = 1'b1;
        din_v[0]   = $urandom;
        lst_v[0]   = 1'b1;
        bcnt_v[0]  = 3'd4;
        step();
        start_v[0] = 1'b0;
        val_v[0]   = 1'b0;
        lst_v[0]   = 1'b0;
        exp_q.push_back(32'hAE42_6082);
        send_beat(0, 32'h49454E44, 1'b1, 3'd4, 1'b0);
        wait_done(0, 1'b1);

        // reset in the middle of FOLD
        do_start(0);
        send_beat(0, $urandom, 1'b0, 3'd0, 1'b0);
        rst = 1'b1;
        #1;
        check("rstfold_rdy",  0, 32'(rdy_v[0]),  32'd0);
        check("rstfold_done", 0, 32'(done_v[0]), 32'd0);
        check("rstfold_valo", 0, 32'(valo_v[0]), 32'd0);
        check("rstfold_dat",  0, dout_v[0], 32'h0);
        step();
        rst = 1'b0;
        val_v[0]  = 1'b1;
        lst_v[0]  = 1'b1;
        bcnt_v[0] = 3'd4;
        din_v[0]  = $urandom;
        repeat (4) step();
        check("post_rst_ignored", 0, 32'(valo_v[0]), 32'd0);
        val_v[0] = 1'b0;
        lst_v[0] = 1'b0;
        step();

        // random messages, random gaps, occasional mid-message restarts
        for (int it = 0; it < 40; it++) begin
            u  = $urandom_range(0, 1);
            nb = $urandom_range(1, 4);
            do_start(u);
            for (int b = 0; b < nb; b++) begin
                send_beat(u, $urandom, b == nb - 1, 3'($urandom_range(0, 7)), 1'b1);
                if (b != nb - 1 && $urandom_range(0, 7) == 0) do_start(u);
            end
            wait_done(u, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
